par2ser_stream: RTL and testbench



---
 rtl/par2ser_stream.sv | 79 +++++++
 tb/tb_par2ser_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/par2ser_stream.sv
// par2ser_stream: parallel-to-serial converter with valid/ready load, one-word holding buffer and selectable bit order.
// Define P2S_PARITY_EN to append an even-parity bit after every word.
module par2ser_stream #(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] parallel_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    output logic              serial_o,
    output logic              valid_o,
    output logic              last_o,
    output logic              empty_o
);
`ifdef P2S_PARITY_EN
    localparam int NB = DATA_W + 1;
    // parity sits at the far end of the shift register so it leaves after the data bits
    function automatic logic [NB-1:0] frame(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w, ^w} : {^w, w};
    endfunction
`else
    localparam int NB = DATA_W;
    function automatic logic [NB-1:0] frame(input logic [DATA_W-1:0] w);
        return w;
    endfunction
`endif
    localparam int CW = $clog2(NB + 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t            state;
    logic [NB-1:0]     sr;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] hold;
    logic              hold_full;
    logic              accept;
    assign accept   = load_valid_i && load_ready_o;
    assign valid_o  = state == SHIFT;
    assign last_o   = valid_o && cnt == CW'(1);
    assign serial_o = valid_o && ((MSB_FIRST != 0) ? sr[NB-1] : sr[0]);
    assign empty_o  = state == IDLE && !hold_full;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sr           <= '0;
            cnt          <= '0;
            hold         <= '0;
            hold_full    <= 1'b0;
            load_ready_o <= 1'b1;
        end else if (state == IDLE) begin
            if (accept) begin
                state <= SHIFT;
                sr    <= frame(parallel_i);
                cnt   <= CW'(NB);
            end
        end else if (cnt != CW'(1)) begin
            sr  <= (MSB_FIRST != 0) ? sr << 1 : sr >> 1;
            cnt <= cnt - CW'(1);
            if (accept) begin
                hold         <= parallel_i;
                hold_full    <= 1'b1;
                load_ready_o <= 1'b0;
            end
        end else if (hold_full) begin
            sr           <= frame(hold);
            cnt          <= CW'(NB);
            hold_full    <= accept;
            load_ready_o <= !accept;
            if (accept) hold <= parallel_i;
        end else if (accept) begin
            sr  <= frame(parallel_i);
            cnt <= CW'(NB);
        end else begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end
    end
endmodule

// File: tb/tb_par2ser_stream.sv
// tb_par2ser_stream: randomized self-checking bench driving an MSB-first and an LSB-first par2ser_stream in parallel.
// The reference model is a queue of pending {bit, last} pairs per bit order.
module tb_par2ser_stream;
    localparam int DATA_W = 8;
`ifdef P2S_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = DATA_W + (PAR ? 1 : 0);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              load_valid_i = 1'b0;
    logic [DATA_W-1:0] parallel_i = '0;
    logic              rdy_m, ser_m, val_m, last_m, emp_m;
    logic              rdy_l, ser_l, val_l, last_l, emp_l;
    logic [4:0]        obs_m, obs_l;
    logic [1:0]        qm[$];
    logic [1:0]        ql[$];
    int                n_checks = 0;
    int                n_fail = 0;

    assign obs_m = {ser_m, val_m, last_m, emp_m, rdy_m};
    assign obs_l = {ser_l, val_l, last_l, emp_l, rdy_l};

    always #5 clk = ~clk;

    par2ser_stream #(.DATA_W(DATA_W), .MSB_FIRST(1)) u_msb (
        .clk(clk), .reset(reset), .parallel_i(parallel_i), .load_valid_i(load_valid_i),
        .load_ready_o(rdy_m), .serial_o(ser_m), .valid_o(val_m), .last_o(last_m), .empty_o(emp_m)
    );

    par2ser_stream #(.DATA_W(DATA_W), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .reset(reset), .parallel_i(parallel_i), .load_valid_i(load_valid_i),
        .load_ready_o(rdy_l), .serial_o(ser_l), .valid_o(val_l), .last_o(last_l), .empty_o(emp_l)
    );

    // words still owed (partly or wholly); more than one means the holding buffer is occupied
    function automatic int nwords();
        int n = 0;
        foreach (qm[i]) n += qm[i][0] ? 1 : 0;
        return n;
    endfunction

    function automatic logic [4:0] exp_vec(input bit msb);
        logic [1:0] f;
        if (qm.size() == 0) return 5'b00011;
        f = msb ? qm[0] : ql[0];
        return {f[1], 1'b1, f[0], 1'b0, nwords() <= 1};
    endfunction

    function automatic void push_word(input logic [DATA_W-1:0] w);
        for (int i = 0; i < DATA_W; i++) begin
            qm.push_back({w[DATA_W-1-i], !PAR && i == DATA_W-1});
            ql.push_back({w[i], !PAR && i == DATA_W-1});
        end
        if (PAR) begin
            qm.push_back({^w, 1'b1});
            ql.push_back({^w, 1'b1});
        end
    endfunction

    // one clock: the bit on the line leaves the model queue, an accepted word joins it
    task automatic tick(output bit acc);
        acc = load_valid_i && !reset && nwords() <= 1;
        @(posedge clk);
        if (reset) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) push_word(parallel_i);
        end
        #1;
    endtask

    task automatic test_reset();
        bit a;
        reset = 1'b1;
        qm.delete();
        ql.delete();
        repeat (3) tick(a);
        reset = 1'b0;
        for (int c = 0; c < 11; c++) begin
            n_checks += 2;
            if (obs_m !== 5'b00011) begin
                n_fail++;
                $display("FAIL reset_idle msb cycle %0d: got %b want 00011", c, obs_m);
            end
            if (obs_l !== 5'b00011) begin
                n_fail++;
                $display("FAIL reset_idle lsb cycle %0d: got %b want 00011", c, obs_l);
            end
            tick(a);
        end
    endtask

    task automatic test_single(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] want_m,
                               input logic [DATA_W-1:0] want_l, input string name);
        bit a;
        logic [DATA_W-1:0] got_m = '0, got_l = '0;
        parallel_i = w;
        load_valid_i = 1'b1;
        tick(a);
        load_valid_i = 1'b0;
        parallel_i = DATA_W'($urandom);
        for (int c = 0; c < NB + 2; c++) begin
            n_checks += 2;
            if (obs_m !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL %s msb cycle %0d: got %b want %b", name, c, obs_m, exp_vec(1));
            end
            if (obs_l !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL %s lsb cycle %0d: got %b want %b", name, c, obs_l, exp_vec(0));
            end
            if (c < DATA_W) begin
                got_m = {got_m[DATA_W-2:0], ser_m};
                got_l = {got_l[DATA_W-2:0], ser_l};
            end
            tick(a);
        end
        n_checks += 2;
        if (got_m !== want_m) begin
            n_fail++;
            $display("FAIL %s msb_sequence: got %h want %h", name, got_m, want_m);
        end
        if (got_l !== want_l) begin
            n_fail++;
            $display("FAIL %s lsb_sequence: got %h want %h", name, got_l, want_l);
        end
    endtask

    task automatic test_stream();
        logic [DATA_W-1:0] w[3] = '{8'hFF, 8'h00, 8'hC3};
        int idx = 0, run = 0, first = -1, lastc = -1, lasts = 0;
        bit a;
        for (int c = 0; c < 200 && (idx < 3 || qm.size() > 0); c++) begin
            parallel_i = idx < 3 ? w[idx] : DATA_W'($urandom);
            load_valid_i = idx < 3;
            tick(a);
            if (a) idx++;
            n_checks += 2;
            if (obs_m !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL stream msb cycle %0d: got %b want %b", c, obs_m, exp_vec(1));
            end
            if (obs_l !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL stream lsb cycle %0d: got %b want %b", c, obs_l, exp_vec(0));
            end
            if (val_m) begin
                if (first < 0) first = c;
                lastc = c;
                run++;
            end
            if (last_m) lasts++;
        end
        load_valid_i = 1'b0;
        n_checks += 3;
        if (run !== 3 * NB) begin
            n_fail++;
            $display("FAIL stream_valid_count: got %0d want %0d", run, 3 * NB);
        end
        if (lastc - first + 1 !== 3 * NB) begin
            n_fail++;
            $display("FAIL stream_gap: span %0d want %0d", lastc - first + 1, 3 * NB);
        end
        if (lasts !== 3) begin
            n_fail++;
            $display("FAIL stream_last_count: got %0d want 3", lasts);
        end
    endtask

    task automatic test_reset_mid();
        bit a;
        parallel_i = 8'hF0;
        load_valid_i = 1'b1;
        tick(a);
        load_valid_i = 1'b0;
        repeat (3) tick(a);
        reset = 1'b1;
        qm.delete();
        ql.delete();
        #1;
        n_checks += 2;
        if (obs_m !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_mid msb: got %b want 00011", obs_m);
        end
        if (obs_l !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_mid lsb: got %b want 00011", obs_l);
        end
        parallel_i = 8'h5A;
        load_valid_i = 1'b1;
        tick(a);
        load_valid_i = 1'b0;
        reset = 1'b0;
        tick(a);
        n_checks += 2;
        if (obs_m !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_no_accept msb: got %b want 00011", obs_m);
        end
        if (obs_l !== 5'b00011) begin
            n_fail++;
            $display("FAIL reset_no_accept lsb: got %b want 00011", obs_l);
        end
        test_single(8'h0F, 8'h0F, 8'hF0, "after_reset_0f");
    endtask

    task automatic test_random();
        bit a;
        for (int c = 0; c < 600 && (c < 500 || qm.size() > 0); c++) begin
            load_valid_i = c < 500 && (c < 250 ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0);
            parallel_i = DATA_W'($urandom);
            tick(a);
            n_checks += 2;
            if (obs_m !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL random msb cycle %0d: got %b want %b", c, obs_m, exp_vec(1));
            end
            if (obs_l !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL random lsb cycle %0d: got %b want %b", c, obs_l, exp_vec(0));
            end
        end
        load_valid_i = 1'b0;
        n_checks++;
        if (obs_m !== 5'b00011) begin
            n_fail++;
            $display("FAIL random_drain msb: got %b want 00011", obs_m);
        end
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, 8'hA5, 8'hA5, "word_a5");
        test_single(8'h01, 8'h01, 8'h80, "word_01");
        test_stream();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
